// File: rtl/button_event_ctrl.sv
// Multi-channel button debouncer: one channel serviced per scan tick, a level is accepted
// after STABLE_TICKS consecutive mismatching services, and accepted changes feed an event FIFO.
module button_event_ctrl #(
    parameter int N_SW         = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_SW-1:0]           sw_in,
    output logic [N_SW-1:0]           sw_level,
    output logic [N_SW-1:0]           press_pulse,
    output logic [N_SW-1:0]           release_pulse,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_SW)-1:0]   evt_id,
    output logic                      evt_press,
    output logic                      overflow,
    input  logic                      clear_overflow
);
    localparam int ID_W  = $clog2(N_SW);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    logic [N_SW-1:0]  sync1;
    logic [N_SW-1:0]  sync2;
    logic [PRE_W-1:0] pre;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt [N_SW];
    logic             tick;
    logic             cur_sync;
    logic             cur_level;
    logic [CNT_W-1:0] cur_cnt;
    logic             mismatch;
    logic             accept;

    logic [ID_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             do_push;
    logic             drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    assign tick = enable && (pre == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (!enable || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (!enable) begin
            ptr <= '0;
        end else if (tick) begin
            ptr <= (ptr == ID_W'(N_SW - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_comb begin
        cur_sync  = sync2[ptr];
        cur_level = sw_level[ptr];
        cur_cnt   = cnt[ptr];
        mismatch  = tick && (cur_sync != cur_level);
        accept    = mismatch && (cur_cnt == CNT_W'(STABLE_TICKS - 1));
    end

    // A matching service breaks the streak, so a bouncing input never accumulates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else if (tick) begin
            if (accept || !mismatch) begin
                cnt[ptr] <= '0;
            end else begin
                cnt[ptr] <= cnt[ptr] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_level      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            if (accept) begin
                sw_level[ptr] <= ~cur_level;
                if (!cur_level) begin
                    press_pulse[ptr] <= 1'b1;
                end else begin
                    release_pulse[ptr] <= 1'b1;
                end
            end
        end
    end

    assign full      = (count == CW'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_push   = accept && (!full || pop);
    assign drop      = accept && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_idx] <= {ptr, ~cur_level};
                wr_idx      <= (wr_idx == AW'(FIFO_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= (rd_idx == AW'(FIFO_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign evt_id    = evt_valid ? mem[rd_idx][ID_W:1] : '0;
    assign evt_press = evt_valid ? mem[rd_idx][0] : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random traffic, all checked each cycle
// against a behavioural model built from cycle counts, streak counts and an event queue.
module tb_button_event_ctrl;
    localparam int N_SW  = 4;
    localparam int TD    = 4;
    localparam int ST    = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sw_in;
    logic [3:0] sw_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       overflow;
    logic       clear_overflow;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .N_SW(N_SW), .TICK_DIV(TD), .STABLE_TICKS(ST), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sw_in(sw_in),
        .sw_level(sw_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_press(evt_press),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    typedef struct {
        logic [1:0] id;
        logic       press;
    } evt_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_d1, m_d2, m_level, m_press, m_rel;
    logic       m_ovf;
    int         m_en_cnt;
    int         m_streak [4];
    int         m_accepts;
    evt_t       m_q [$];

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
        m_ovf = 1'b0; m_en_cnt = 0;
        for (int i = 0; i < N_SW; i++) m_streak[i] = 0;
        m_q.delete();
    endtask

    // Channel ch is due on the tick ending each TD-cycle slot; channels take slots in turn.
    task automatic model_edge();
        logic [3:0] synced;
        bit         dropped;
        int         ch;
        evt_t       e;
        synced  = m_d2;
        m_d2    = m_d1;
        m_d1    = sw_in;
        dropped = 0;
        m_press = '0;
        m_rel   = '0;
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        if (!enable) begin
            m_en_cnt = 0;
            for (int i = 0; i < N_SW; i++) m_streak[i] = 0;
        end else begin
            if (m_en_cnt % TD == TD - 1) begin
                ch = (m_en_cnt / TD) % N_SW;
                if (synced[ch] != m_level[ch]) begin
                    if (m_streak[ch] + 1 == ST) begin
                        m_streak[ch] = 0;
                        m_level[ch]  = ~m_level[ch];
                        if (m_level[ch]) m_press[ch] = 1'b1;
                        else             m_rel[ch]   = 1'b1;
                        m_accepts++;
                        e.id    = 2'(ch);
                        e.press = m_level[ch];
                        if (m_q.size() < DEPTH) m_q.push_back(e);
                        else                    dropped = 1;
                    end else begin
                        m_streak[ch]++;
                    end
                end else begin
                    m_streak[ch] = 0;
                end
            end
            m_en_cnt++;
        end
        if (dropped)             m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
    endtask

    function automatic bit will_push();
        int ch;
        if (!enable || (m_en_cnt % TD != TD - 1)) return 0;
        ch = (m_en_cnt / TD) % N_SW;
        return (m_d2[ch] != m_level[ch]) && (m_streak[ch] + 1 == ST);
    endfunction

    task automatic step();
        logic exp_valid;
        @(posedge clk);
        model_edge();
        #1;
        exp_valid = (m_q.size() > 0);
        n_checks++;
        if ({sw_level, press_pulse, release_pulse, evt_valid, overflow} !==
            {m_level, m_press, m_rel, exp_valid, m_ovf}) begin
            n_fail++;
            $display("FAIL lockstep t=%0t lvl/prs/rel/vld/ovf got %b %b %b %b %b expected %b %b %b %b %b",
                     $time, sw_level, press_pulse, release_pulse, evt_valid, overflow,
                     m_level, m_press, m_rel, exp_valid, m_ovf);
        end
        if (exp_valid) begin
            n_checks++;
            if ({evt_id, evt_press} !== {m_q[0].id, m_q[0].press}) begin
                n_fail++;
                $display("FAIL evt_head t=%0t id/press got %0d/%b expected %0d/%b",
                         $time, evt_id, evt_press, m_q[0].id, m_q[0].press);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; sw_in = '0; evt_ready = 1'b0; clear_overflow = 1'b0;
        model_clear();
        m_accepts = 0;
        #12;
        n_checks++;
        if ({sw_level, press_pulse, release_pulse, evt_valid, evt_id, evt_press, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %b expected all zero",
                     {sw_level, press_pulse, release_pulse, evt_valid, evt_id, evt_press, overflow});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_single_press();
        int k;
        bit found;
        sw_in = 4'b0001; enable = 1'b1;
        k = 0; found = 0;
        while (k < 80 && !found) begin
            k++;
            step();
            if (press_pulse[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found || k != 36) begin
            n_fail++;
            $display("FAIL press_latency got found=%0d edge=%0d expected edge 36", found, k);
        end
        n_checks++;
        if ({sw_level, evt_valid, evt_id, evt_press} !== {4'b0001, 1'b1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_event got lvl=%b vld=%b id=%0d prs=%b expected 0001 1 0 1",
                     sw_level, evt_valid, evt_id, evt_press);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_drain evt_valid got %b expected 0", evt_valid);
        end
    endtask

    task automatic test_bounce();
        bit bad;
        bad = 0;
        for (int c = 0; c < 320; c++) begin
            if (c % 20 == 0) sw_in[2] = ~sw_in[2];
            step();
            if (press_pulse[2] !== 1'b0 || evt_valid !== 1'b0) bad = 1;
        end
        sw_in[2] = 1'b0;
        for (int c = 0; c < 20; c++) step();
        n_checks++;
        if (bad || sw_level[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce got bad=%0d lvl2=%b expected 0 0", bad, sw_level[2]);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] target;
        logic [3:0] seen;
        int base, pops;
        target = 4'b1110;
        base = m_accepts;
        evt_ready = 1'b0;
        sw_in = target;
        for (int i = 0; i < 300 && m_accepts < base + 4; i++) step();
        sw_in[1] = 1'b0;
        for (int i = 0; i < 300 && m_accepts < base + 5; i++) step();
        n_checks++;
        if (m_accepts != base + 5) begin
            n_fail++;
            $display("FAIL ovf_timeout got %0d accepts expected %0d", m_accepts - base, 5);
        end
        n_checks++;
        if (overflow !== 1'b1 || sw_level !== 4'b1100) begin
            n_fail++;
            $display("FAIL ovf_set got ovf=%b lvl=%b expected 1 1100", overflow, sw_level);
        end
        pops = 0; seen = '0;
        for (int i = 0; i < 200 && evt_valid === 1'b1; i++) begin
            evt_ready = 1'($urandom_range(0, 1));
            if (evt_ready) begin
                pops++;
                n_checks++;
                if (evt_press !== target[evt_id] || seen[evt_id]) begin
                    n_fail++;
                    $display("FAIL ovf_drain id=%0d got press=%b dup=%b expected press=%b dup=0",
                             evt_id, evt_press, seen[evt_id], target[evt_id]);
                end
                seen[evt_id] = 1'b1;
            end
            step();
        end
        evt_ready = 1'b0;
        n_checks++;
        if (pops != 4) begin
            n_fail++;
            $display("FAIL ovf_count got %0d events expected 4", pops);
        end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int base, pops;
        base = m_accepts;
        evt_ready = 1'b0;
        sw_in = 4'b0011;
        for (int i = 0; i < 300 && m_accepts < base + 4; i++) step();
        sw_in[3] = 1'b1;
        for (int i = 0; i < 300 && m_accepts < base + 5; i++) begin
            evt_ready = will_push();
            step();
        end
        evt_ready = 1'b0;
        n_checks++;
        if (m_accepts != base + 5 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop got accepts=%0d ovf=%b expected 5 0", m_accepts - base, overflow);
        end
        pops = 0;
        for (int i = 0; i < 20 && evt_valid === 1'b1; i++) begin
            evt_ready = 1'b1;
            step();
            pops++;
        end
        evt_ready = 1'b0;
        n_checks++;
        if (pops != 4) begin
            n_fail++;
            $display("FAIL push_pop_occupancy got %0d expected 4", pops);
        end
    endtask

    task automatic test_enable_drop();
        int k;
        bit found;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        sw_in = 4'b1001;
        for (int i = 0; i < 100 && m_streak[1] < 2; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (sw_level !== 4'b1011 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_hold got lvl=%b vld=%b expected 1011 0", sw_level, evt_valid);
        end
        enable = 1'b1;
        k = 0; found = 0;
        while (k < 100 && !found) begin
            k++;
            step();
            if (release_pulse[1] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found || k != 40) begin
            n_fail++;
            $display("FAIL reenable_latency got found=%0d edge=%0d expected edge 40", found, k);
        end
        evt_ready = 1'b1;
        step();
        step();
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b1;
        sw_in = 4'b0000;
        for (int i = 0; i < 300 && m_level != 4'b0000; i++) step();
        for (int i = 0; i < 3; i++) step();
        evt_ready = 1'b0;
        sw_in = 4'b1010;
        for (int i = 0; i < 300 && m_level != 4'b1010; i++) step();
        step();
        n_checks++;
        if (sw_level !== 4'b1010 || evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got lvl=%b vld=%b expected 1010 1", sw_level, evt_valid);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({sw_level, press_pulse, release_pulse, evt_valid, evt_id, evt_press, overflow} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %b expected all zero",
                     {sw_level, press_pulse, release_pulse, evt_valid, evt_id, evt_press, overflow});
        end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard evt_valid got %b expected 0", evt_valid);
        end
    endtask

    task automatic test_random();
        int b;
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                b = $urandom_range(0, 3);
                sw_in[b] = ~sw_in[b];
            end
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            evt_ready      = ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 63) == 0);
            step();
        end
        evt_ready = 1'b0;
        clear_overflow = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
